// File: rtl/ln_pkg.sv
// ln_pkg: shared constants, FSM state type and the truncating Q16.16 multiply
// used by the natural-logarithm unit (ln_taylor) and its divider.
//   ONE_Q16            : 1.0 in Q16.16
//   LN2_Q16            : ln(2) in Q16.16
//   RECIP_3/5/7        : 1/3, 1/5, 1/7 in Q16.16 (atanh series coefficients)
//   DIV_ITERS          : quotient bits produced by the fractional divider
//   state_e            : ln_taylor sequencing states
//   fx_mult(a, b)      : bits [47:16] of the 64-bit unsigned product
package ln_pkg;

  localparam logic [31:0] ONE_Q16   = 32'd65536;
  localparam logic [31:0] LN2_Q16   = 32'd45426;
  localparam logic [31:0] RECIP_3   = 32'd21845;
  localparam logic [31:0] RECIP_5   = 32'd13107;
  localparam logic [31:0] RECIP_7   = 32'd9362;
  localparam int          DIV_ITERS = 16;

  typedef enum logic [2:0] {
    IDLE,
    NORM,
    DIV,
    SQ,
    POW,
    ACC,
    FIN,
    DONE
  } state_e;

  // Truncating Q16.16 multiply: drop the low 16 fraction bits, keep 32 bits.
  function automatic logic [31:0] fx_mult(input logic [31:0] a, input logic [31:0] b);
    return 32'(({32'd0, a} * {32'd0, b}) >> 16);
  endfunction

endpackage

// File: rtl/fx_div_seq.sv
// fx_div_seq: sequential restoring fractional divider, one quotient bit per
// cycle, MSB first. The first iteration happens on the start edge, so quo
// holds floor(num * 2^16 / den) and done pulses one cycle after the 16th edge
// counted from (and including) the start edge. Requires num < den.
//   clk   in   clock, rising edge
//   rst   in   synchronous active-high reset
//   start in   load num/den and begin (may restart a busy divider)
//   num   in   dividend (Q16.16, < den)
//   den   in   divisor
//   done  out  one-cycle pulse: quo is final
//   quo   out  quotient, Q16.16 with zero integer part
module fx_div_seq
  import ln_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] num,
  input  logic [31:0] den,
  output logic        done,
  output logic [31:0] quo
);

  logic [31:0] rem_q, rem_d;
  logic [31:0] den_q, den_d;
  logic [31:0] quo_q, quo_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [31:0] rem_in, den_in, rem_sh, quo_base;
  logic        q_bit;

  always_comb begin
    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    rem_in   = start ? num : rem_q;
    den_in   = start ? den : den_q;
    quo_base = start ? 32'd0 : quo_q;
    rem_sh   = rem_in << 1;
    q_bit    = (rem_sh >= den_in);

    rem_d  = rem_q;
    den_d  = den_q;
    quo_d  = quo_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;

    if (start || busy_q) begin
      rem_d = q_bit ? (rem_sh - den_in) : rem_sh;
      quo_d = {quo_base[30:0], q_bit};
    end

    if (start) begin
      den_d  = den;
      cnt_d  = 5'(DIV_ITERS - 1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      cnt_d = cnt_q - 5'd1;
      if (cnt_q == 5'd1) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      rem_q  <= '0;
      den_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      den_q  <= den_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;
  assign quo  = quo_q;

endmodule

// File: rtl/ln_taylor.sv
// ln_taylor: sequential Q16.16 natural logarithm.
// ln(x) = k*ln2 + 2*atanh(z), x = m*2^k, m in [1,2), z = (m-1)/(m+1),
// atanh(z) ~= z + z^3/3 + z^5/5 + z^7/7.
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset
//   in_valid  in   operand valid
//   in_ready  out  idle, operand accepted on in_valid & in_ready
//   x_in      in   unsigned Q16.16 operand
//   out_valid out  result valid, held until out_ready
//   out_ready in   consumer accepts result
//   y_out     out  signed Q16.16 ln(x_in)
//   err       out  x_in was zero (y_out = 0x8000_0000)
module ln_taylor
  import ln_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y_out,
  output logic        err
);

  state_e state_q, state_d;

  logic [31:0]       x_q, x_d;
  logic signed [5:0] k_q, k_d;
  logic [31:0]       z2_q, z2_d;
  logic [31:0]       term_q, term_d;
  logic [31:0]       sum_q, sum_d;
  logic [1:0]        idx_q, idx_d;
  logic [31:0]       y_q, y_d;
  logic              err_q, err_d;

  // Leading-one detection and normalisation of the latched operand.
  logic [4:0]        lead_pos;
  logic [31:0]       mant;
  logic signed [5:0] k_norm;

  always_comb begin
    lead_pos = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (x_q[i]) lead_pos = 5'(i);
    end
    // Place the leading one at bit 16; low bits shifted out are truncated.
    if (lead_pos >= 5'd16) mant = x_q >> (lead_pos - 5'd16);
    else                   mant = x_q << (5'd16 - lead_pos);
    k_norm = $signed({1'b0, lead_pos}) - 6'sd16;
  end

  // Divider: z = (m - 1) / (m + 1), started from NORM for nonzero operands.
  logic        div_start, div_done;
  logic [31:0] div_quo;

  assign div_start = (state_q == NORM) && (x_q != 32'd0);

  fx_div_seq u_div (
    .clk   (clk),
    .rst   (rst),
    .start (div_start),
    .num   (mant - ONE_Q16),
    .den   (mant + ONE_Q16),
    .done  (div_done),
    .quo   (div_quo)
  );

  logic [31:0]        recip;
  logic signed [31:0] k_ext, k_ln2;

  always_comb begin
    case (idx_q)
      2'd0:    recip = RECIP_3;
      2'd1:    recip = RECIP_5;
      default: recip = RECIP_7;
    endcase
    k_ext = {{26{k_q[5]}}, k_q};
    k_ln2 = k_ext * $signed(LN2_Q16);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = NORM;
      NORM:    state_d = (x_q == 32'd0) ? DONE : DIV;
      DIV:     if (div_done) state_d = SQ;
      SQ:      state_d = POW;
      POW:     state_d = ACC;
      ACC:     state_d = (idx_q == 2'd2) ? FIN : POW;
      FIN:     state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Datapath next-state; y/err only move on the edge that enters DONE.
  always_comb begin
    x_d    = x_q;
    k_d    = k_q;
    z2_d   = z2_q;
    term_d = term_q;
    sum_d  = sum_q;
    idx_d  = idx_q;
    y_d    = y_q;
    err_d  = err_q;
    case (state_q)
      IDLE: if (in_valid) x_d = x_in;
      NORM: begin
        if (x_q == 32'd0) begin
          err_d = 1'b1;
          y_d   = 32'h8000_0000;
        end else begin
          k_d = k_norm;
        end
      end
      SQ: begin
        z2_d   = fx_mult(div_quo, div_quo);
        term_d = div_quo;
        sum_d  = div_quo;
        idx_d  = 2'd0;
      end
      POW: term_d = fx_mult(term_q, z2_q);
      ACC: begin
        sum_d = sum_q + fx_mult(term_q, recip);
        idx_d = idx_q + 2'd1;
      end
      FIN: begin
        y_d   = 32'(k_ln2) + (sum_q << 1);
        err_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q    <= '0;
      k_q    <= '0;
      z2_q   <= '0;
      term_q <= '0;
      sum_q  <= '0;
      idx_q  <= '0;
      y_q    <= '0;
      err_q  <= 1'b0;
    end else begin
      x_q    <= x_d;
      k_q    <= k_d;
      z2_q   <= z2_d;
      term_q <= term_d;
      sum_q  <= sum_d;
      idx_q  <= idx_d;
      y_q    <= y_d;
      err_q  <= err_d;
    end
  end

  assign y_out = y_q;
  assign err   = err_q;

endmodule

// File: tb/tb_ln_taylor.sv
// tb_ln_taylor: directed self-checking bench for ln_taylor.
// Inputs are driven on the falling edge, outputs sampled 1 time unit after the
// rising edge.
module tb_ln_taylor;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y_out;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ln_taylor dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y_out     (y_out),
    .err       (err)
  );

  // Compare obs against exp as signed values, accepting |obs - exp| <= tol.
  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp, input int tol);
    longint diff;
    n_checks++;
    diff = longint'($signed(obs)) - longint'($signed(exp));
    if (diff > longint'(tol) || diff < -longint'(tol)) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  // Present x for one accept edge, then count edges until out_valid (bounded).
  task automatic launch(input logic [31:0] x, output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    x_in     = x;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x_in     = 32'hDEAD_BEEF;
    lat      = 0;
    while (!out_valid && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run_op(input logic [31:0] x, output logic [31:0] y,
                        output logic e, output int lat);
    launch(x, lat);
    y = y_out;
    e = err;
    accept();
  endtask

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        e;
    int          lat;
    int          tol;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] y;
    logic        e;
    int          lat;
    logic [31:0] xr;
    real         ln_ref;
    int          exp_i;

    // Hand-computed: exact powers of two, zero, and near-e / extremes within 8 LSB.
    vecs[0] = '{32'h0001_0000, 32'h0000_0000, 1'b0, 25, 0};
    vecs[1] = '{32'h0002_0000, 32'h0000_B172, 1'b0, 25, 0};
    vecs[2] = '{32'h0000_8000, 32'hFFFF_4E8E, 1'b0, 25, 0};
    vecs[3] = '{32'h0000_0000, 32'h8000_0000, 1'b1,  1, 0};
    vecs[4] = '{32'h0002_B7E1, 32'h0001_0000, 1'b0, 25, 8};
    vecs[5] = '{32'h0000_0001, 32'hFFF4_E8E0, 1'b0, 25, 8};
    vecs[6] = '{32'hFFFF_FFFF, 32'h000B_171F, 1'b0, 25, 8};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x_in      = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(in_ready),  32'd1, 0);
    check("rst_out_valid", 32'(out_valid), 32'd0, 0);
    check("rst_y",         y_out,          32'd0, 0);
    check("rst_err",       32'(err),       32'd0, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].x, y, e, lat);
      check($sformatf("vec%0d_y", i),   y,         vecs[i].y,        vecs[i].tol);
      check($sformatf("vec%0d_err", i), 32'(e),    32'(vecs[i].e),   0);
      check($sformatf("vec%0d_lat", i), 32'(lat),  32'(vecs[i].lat), 0);
    end

    // Backpressure: result for 2.0 must sit unchanged while in_valid pulses.
    launch(32'h0002_0000, lat);
    check("bp_lat", 32'(lat), 32'd25, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = i[0];
      x_in     = 32'h0000_1234;
      @(posedge clk);
      #1;
      check("bp_y",         y_out,          32'h0000_B172, 0);
      check("bp_out_valid", 32'(out_valid), 32'd1,         0);
      check("bp_in_ready",  32'(in_ready),  32'd0,         0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    accept();
    check("bp_rel_in_ready",  32'(in_ready),  32'd1,         0);
    check("bp_rel_out_valid", 32'(out_valid), 32'd0,         0);
    check("bp_rel_y_hold",    y_out,          32'h0000_B172, 0);

    // Reset during divider cycle 8 aborts the operation.
    @(negedge clk);
    in_valid = 1'b1;
    x_in     = 32'h0004_0000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("busy_in_ready", 32'(in_ready), 32'd0, 0);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0, 0);
    check("mid_rst_in_ready",  32'(in_ready),  32'd1, 0);
    check("mid_rst_y",         y_out,          32'd0, 0);
    @(negedge clk);
    rst = 1'b0;
    run_op(32'h0002_0000, y, e, lat);
    check("post_rst_y",   y,        32'h0000_B172, 0);
    check("post_rst_lat", 32'(lat), 32'd25,        0);

    // Random operands against a real-valued ln. The datapath only truncates,
    // so it reads low: accept 14 LSB below to 6 LSB above the true value.
    for (int i = 0; i < 1000; i++) begin
      xr = $urandom();
      if (xr == 32'd0) xr = 32'd1;
      run_op(xr, y, e, lat);
      ln_ref = $ln(real'(xr) / 65536.0) * 65536.0;
      exp_i  = $rtoi(ln_ref + ((ln_ref >= 0.0) ? 0.5 : -0.5)) - 4;
      check($sformatf("rand_x%08h", xr), y, 32'(exp_i), 10);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
